// File: rtl/random_latency_gen_pkg.sv
// random_latency_pkg: shared enums and default LFSR constants for the latency stage
package random_latency_pkg;
  typedef enum logic [1:0] {MODE_RANDOM = 2'd0, MODE_FIXED = 2'd1, MODE_MIN = 2'd2} dly_mode_e;
  typedef enum logic [1:0] {IDLE, COUNT, RESP} fsm_state_e;
  localparam logic [9:0]  TAPS_10 = 10'h240;
  localparam logic [9:0]  SEED_10 = 10'h001;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'hACE1;
endpackage

// File: rtl/random_latency_gen_if.sv
// random_latency_gen_if: request/response handshake bundle
interface random_latency_gen_if;
  logic req_valid;
  logic req_ready;
  logic resp_valid;
  logic resp_ready;
  modport master (output req_valid, resp_ready, input req_ready, resp_valid);
  modport slave (input req_valid, resp_ready, output req_ready, resp_valid);
endinterface

// File: rtl/random_latency_gen_lfsr.sv
// lfsr_galois: free-running Galois LFSR with reseed and all-zero protection
module lfsr_galois #(
  parameter int W = 16,
  parameter logic [W-1:0] TAPS = W'(16'hB400),
  parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);
  logic [W-1:0] r_lfsr;
  assign value = r_lfsr;
  // reseed wins over the shift; a zero seed falls back to SEED so the register never locks up
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_lfsr <= SEED;
    else if (load) r_lfsr <= (load_val == '0) ? SEED : load_val;
    else r_lfsr <= {1'b0, r_lfsr[W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
endmodule

// File: rtl/random_latency_gen.sv
// random_latency_gen: accepts one request and answers after a random, fixed or minimum latency
module random_latency_gen
  import random_latency_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(TAPS_16),
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(SEED_16),
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 10,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  random_latency_gen_if.slave bus,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  fixed_dly,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  output logic              busy,
  output logic [CNT_W-1:0]  cur_dly
);
  localparam int RANGE = MAX_DLY - MIN_DLY + 1;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DLY);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DLY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if (SEED == '0) begin : g_chk_seed
    $error("SEED must be non-zero");
  end
  if (MIN_DLY < 1) begin : g_chk_min
    $error("MIN_DLY must be >= 1");
  end
  if (MAX_DLY < MIN_DLY) begin : g_chk_order
    $error("MAX_DLY must be >= MIN_DLY");
  end
  if (64'(MAX_DLY) >= (64'd1 << CNT_W)) begin : g_chk_cnt
    $error("MAX_DLY must fit in CNT_W bits");
  end

  fsm_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_cur_dly, w_cur_dly_nxt;
  logic [CNT_W-1:0] w_rand_dly, w_fixed_dly, w_dly;
  logic [LFSR_W-1:0] w_lfsr;
  logic w_idle;

  lfsr_galois #(.W(LFSR_W), .TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
    .clk(clk),
    .reset_n(reset_n),
    .load(seed_load),
    .load_val(seed_val),
    .value(w_lfsr)
  );

  assign w_rand_dly  = MIN_C + CNT_W'(32'(w_lfsr) % 32'(RANGE));
  assign w_fixed_dly = (fixed_dly < MIN_C) ? MIN_C : (fixed_dly > MAX_C) ? MAX_C : fixed_dly;
  assign w_dly = (mode == MODE_FIXED) ? w_fixed_dly : (mode == MODE_MIN) ? MIN_C : w_rand_dly;

  assign w_idle         = r_state == IDLE;
  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = r_state == RESP;
  assign busy           = !w_idle;
  assign cur_dly        = r_cur_dly;

  // next state: latch the delay on acceptance, count down, then hold the response until consumed
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cur_dly_nxt = r_cur_dly;
    unique case (r_state)
      IDLE: if (bus.req_valid) begin
        w_cur_dly_nxt = w_dly;
        w_cnt_nxt     = w_dly - ONE;
        w_state_nxt   = (w_dly == ONE) ? RESP : COUNT;
      end
      COUNT: begin
        w_cnt_nxt   = r_cnt - ONE;
        w_state_nxt = (r_cnt == ONE) ? RESP : COUNT;
      end
      RESP: w_state_nxt = bus.resp_ready ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register; reset aborts any in-flight transaction
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cur_dly <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_dly <= w_cur_dly_nxt;
    end
endmodule
